// File: rtl/pwm_pkg.sv
// Shared constants for the PWM duty-ramp scheduler.
package pwm_pkg;

    localparam int PWM_NCH = 4;   // PWM channels
    localparam int PWM_DW  = 8;   // duty / target / step width
    localparam int PWM_CW  = 2;   // channel-index width, 2**PWM_CW >= PWM_NCH

    // Register selected by a write.
    localparam logic WSEL_TARGET = 1'b0;
    localparam logic WSEL_STEP   = 1'b1;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Register-write port of the ramp scheduler.
//
// Handshake: a write is a single-cycle strobe. When wr_en is high at a rising
// clk edge, wr_data is stored into the register picked by wr_sel/wr_ch. There
// is no ready/back-pressure; the slave accepts every strobe, and a write to a
// channel index that does not exist is silently dropped.
interface pwm_ramp_ctrl_if #(
    parameter int DW = 8,
    parameter int CW = 2
);
    logic          wr_en;
    logic          wr_sel;
    logic [CW-1:0] wr_ch;
    logic [DW-1:0] wr_data;

    modport master (output wr_en, output wr_sel, output wr_ch, output wr_data);
    modport slave  (input  wr_en, input  wr_sel, input  wr_ch, input  wr_data);
endinterface

// File: rtl/pwm_ramp_lane.sv
// One channel of the ramp scheduler: target/step/current registers and the
// saturating move of current toward target on each tick.
module pwm_ramp_lane
    import pwm_pkg::*;
#(
    parameter int DW = PWM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic          wr_sel,
    input  logic [DW-1:0] wr_data,
    input  logic          tick,
    output logic [DW-1:0] current,
    output logic          at_target
);

    logic [DW-1:0] target_q, target_d;
    logic [DW-1:0] step_q, step_d;
    logic [DW-1:0] current_q, current_d;

    // One extra bit on both so the add cannot wrap and the subtract cannot
    // underflow before the clamp against target.
    logic        [DW:0] sum;
    logic signed [DW:0] diff;

    // Next-state: ramp from the registered (pre-write) target/step, then
    // apply any write so a same-cycle write only affects the next tick.
    always_comb begin
        target_d  = target_q;
        step_d    = step_q;
        current_d = current_q;
        sum       = {1'b0, current_q} + {1'b0, step_q};
        diff      = $signed({1'b0, current_q}) - $signed({1'b0, step_q});

        if (tick) begin
            if (step_q == '0) begin
                current_d = target_q;
            end else if (current_q < target_q) begin
                current_d = (sum > {1'b0, target_q}) ? target_q : sum[DW-1:0];
            end else if (current_q > target_q) begin
                current_d = (diff < $signed({1'b0, target_q})) ? target_q : diff[DW-1:0];
            end
        end

        if (wr) begin
            if (wr_sel == WSEL_TARGET) begin
                target_d = wr_data;
            end else begin
                step_d = wr_data;
            end
        end
    end

    // Lane registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q  <= '0;
            step_q    <= '0;
            current_q <= '0;
        end else begin
            target_q  <= target_d;
            step_q    <= step_d;
            current_q <= current_d;
        end
    end

    assign current   = current_q;
    assign at_target = (current_q == target_q);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle scheduler: NCH ramp lanes updated once per PWM period, plus the
// busy flag and the one-cycle ramp_done pulse after the last lane settles.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int NCH = PWM_NCH,
    parameter int DW  = PWM_DW,
    parameter int CW  = PWM_CW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    pwm_ramp_ctrl_if.slave    wr_bus,
    input  logic              period_end,
    output logic [NCH*DW-1:0] duty_o,
    output logic              busy,
    output logic              ramp_done
);

    logic           tick;
    logic [NCH-1:0] lane_wr;
    logic [NCH-1:0] at_target;
    logic           busy_q, busy_d;
    logic           ramp_done_q, ramp_done_d;

    // Disabled scheduler ignores period boundaries entirely.
    assign tick = period_end & ena;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        // Indices at or above NCH match no lane, so such writes are dropped.
        assign lane_wr[k] = wr_bus.wr_en && (wr_bus.wr_ch == CW'(k));

        pwm_ramp_lane #(
            .DW(DW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr       (lane_wr[k]),
            .wr_sel   (wr_bus.wr_sel),
            .wr_data  (wr_bus.wr_data),
            .tick     (tick),
            .current  (duty_o[k*DW +: DW]),
            .at_target(at_target[k])
        );
    end

    assign busy = ~&at_target;

    // Falling-edge detect on busy; busy_q resets low so reset never pulses.
    always_comb begin
        busy_d      = busy;
        ramp_done_d = busy_q & ~busy;
    end

    // Edge-detect history and registered ramp_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            ramp_done_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            ramp_done_q <= ramp_done_d;
        end
    end

    assign ramp_done = ramp_done_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Duty-cycle scheduler for the PWM datapath of tt_um_code123456_pwm.
- Holds a target duty and a slew step for each of NCH PWM channels, written over a simple register-write port.
- Once per PWM period, when the PWM counter asserts period_end, moves each channel's live duty toward its target by its step.
- The live duties it drives change only at period boundaries, so the PWM outputs see soft-start/soft-stop ramps and never a glitched period.

Parameters:
- NCH, 4: number of PWM channels.
- DW, 8: duty width in bits; also the width of the target and step registers.
- CW, 2: channel-index width; must satisfy 2^CW >= NCH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  scheduler enable; low freezes the ramp.
- wr_en  in  1  register write strobe, one cycle per write.
- wr_sel  in  1  write target: 0 = target duty, 1 = step.
- wr_ch  in  CW  channel index for the write.
- wr_data  in  DW  value written.
- period_end  in  1  one-cycle pulse from the PWM counter on the last count of each period.
- duty_o  out  NCH*DW  live duties; channel k occupies bits [k*DW +: DW].
- busy  out  1  high while any channel has current != target.
- ramp_done  out  1  one-cycle pulse on the cycle after busy falls.

Behaviour:
- Reset values:
  - target[k] = 0, step[k] = 0, current[k] = 0 for every channel.
  - duty_o = 0, busy = 0, ramp_done = 0.
- Reset is asynchronous. Asserting rst_n mid-ramp clears all state immediately.
- Writes:
  - On a clk edge with wr_en = 1, wr_data is stored in target[wr_ch] (wr_sel = 0) or step[wr_ch] (wr_sel = 1).
  - wr_ch >= NCH: the write is ignored and no state changes.
  - Writes are accepted regardless of ena.
- Ramp update: only on a clk edge with period_end = 1 and ena = 1. For each channel k independently:
  - step[k] = 0: current <= target (immediate jump).
  - current < target: current <= min(current + step, target). Sum is computed in DW+1 bits, so it never wraps.
  - current > target: current <= max(current - step, target). Difference is computed in DW+1 bits signed, so it never underflows.
  - current == target: no change.
- Simultaneous write and period_end on the same channel: the ramp uses the pre-write target/step. The new value takes effect at the next period_end.
- ena = 0: current is frozen, period_end is ignored, busy still reflects current != target.
- Latency: duty_o is registered and equals current. A new duty is visible one cycle after the period_end edge, so it applies to the full next PWM period.
- busy is combinational from registered state (OR over channels of current != target). A target write makes it rise the cycle after the write.
- ramp_done is registered: it is 1 for exactly one cycle when busy was 1 in the previous cycle and is 0 now. No pulse on reset.
- Target rewritten mid-ramp: the ramp simply reverses or retargets at the next period_end; there is no error condition.

Decomposition:
- Package pwm_pkg:
  - Constants PWM_NCH, PWM_DW, PWM_CW.
  - Localparams WSEL_TARGET = 0 and WSEL_STEP = 1.
- Sub-module pwm_ramp_lane:
  - One channel: its target/step/current registers and the saturating step logic.
  - Ports: clk, rst_n, wr, wr_sel, wr_data, tick, current, at_target.
- pwm_ramp_ctrl:
  - Decodes wr_ch into per-lane wr.
  - Generates NCH lanes; tick = period_end & ena.
  - Reduces at_target to busy and builds the ramp_done pulse.

Test Plan:
- Reset then idle: hold rst_n = 0 for 5 cycles, then release. Expect duty_o = 0, busy = 0, ramp_done never 1 over 100 cycles with period_end pulsing every 16 cycles.
- Up-ramp: step[0] = 10, target[0] = 35, period_end every 16 cycles. Expect ch0 duty 10, 20, 30, 35 on successive periods; busy = 1 until 35; ramp_done pulses once; other channels stay 0.
- Down-ramp with immediate jump:
  - ch1 at 200; step[1] = 0, target[1] = 5 → duty 5 after the first period_end.
  - Then step[1] = 255, target[1] = 250 → 250 next period.
  - Then target[1] = 0 → duty 0 in one period, with no wrap below 0.
- Saturation: step[2] = 200, target[2] = 255 from 100 → duty 255, never a wrapped value.
- Collision and freeze:
  - Write target[3] = 50 in the same cycle as period_end → duty_o ch3 unchanged that period, reaches the step-limited value after the next period_end.
  - With ena = 0, duty is frozen across 3 period_end pulses.
- Reset mid-ramp: drop rst_n between two period_end pulses during the up-ramp → all duties 0 immediately; no ramp_done pulse; writes to wr_ch = 3 with NCH = 3 are ignored.
